uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Serial receive engine of the UART core; produces the `uart_data_out`, `uart_rx_busy` and `done` signals that the bus-facing UART peripheral reads back.
- Armed by a one-shot or level `init_rx` from that peripheral.
- Synchronises the `uart_rx` pin, detects and validates the start bit, samples 8 data bits LSB-first at mid-bit, and checks the stop bit.
- Format is 8N1 only; no parity, no FIFO.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bits/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (integer division, 434 at defaults), clocks per bit; derived, not overridden.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- init_rx  input  1  arm request; sampled only in IDLE.
- uart_rx  input  1  asynchronous serial line, idle high.
- uart_data_out  output  8  last correctly received byte.
- uart_rx_busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a byte is accepted.
- frame_err  output  1  sticky; set on bad stop bit, cleared on next arm.

Behaviour:
- Reset values (rst high at a clk edge):
  - state=IDLE, uart_data_out=8'h00, uart_rx_busy=0, done=0, frame_err=0.
  - Synchroniser flops=1, bit counter=0, baud counter=0.
  - Reset mid-frame aborts immediately; no done pulse.
- Input path: 2-flop synchroniser on uart_rx; `rx_s` is the second flop. All decisions use `rx_s`, so the start edge is seen 2 clocks after the pin.
- IDLE:
  - If init_rx=1, go to WAIT_START next cycle and clear frame_err.
  - init_rx in any other state is ignored.
- WAIT_START:
  - On rx_s=0, go to START with baud counter=0.
  - Waits indefinitely.
- START:
  - Count to CLKS_PER_BIT/2 - 1 (216).
  - At terminal count, re-check rx_s:
    - rx_s=0: go to DATA, baud counter=0, bit index=0.
    - rx_s=1: glitch; return to WAIT_START. No error flagged.
- DATA:
  - Count to CLKS_PER_BIT-1 (433). At terminal count, shift rx_s into shift_reg[bit index] (LSB first), then increment bit index.
  - After bit index 7 is sampled, go to STOP.
- STOP:
  - Count to CLKS_PER_BIT-1. At terminal count:
    - rx_s=1: uart_data_out<=shift_reg, done=1 for exactly one cycle, go to IDLE.
    - rx_s=0: frame_err<=1, uart_data_out unchanged, no done, go to IDLE.
- uart_rx_busy is registered: it is 1 starting the cycle after leaving IDLE and 0 the cycle after returning to IDLE. It is 0 in the same cycle done is high.
- Latency: done asserts ≈9.5 bit periods + 3 clocks after the falling pin edge of the start bit.
- Counters: baud counter 9 bits at defaults, width = $clog2(CLKS_PER_BIT); bit index 3 bits. No wrap beyond terminal count; the counter is reset on every state change.
- Back-to-back frames: after done, re-arming requires init_rx while in IDLE. A start bit arriving before re-arm is ignored (the line is not buffered).
- uart_data_out holds its value until the next valid byte.

Test Plan:
- Reset: hold rst 3 cycles with uart_rx=1 -> uart_data_out=00, uart_rx_busy=0, done=0, frame_err=0.
- Nominal: pulse init_rx, send 8'hA5 (bits 1,0,1,0,0,1,0,1 LSB-first) at 434 clk/bit -> uart_rx_busy=1 the cycle after arm; single-cycle done; uart_data_out=A5; frame_err=0; busy=0 in the done cycle.
- Glitch: armed, drive uart_rx low for 100 clocks then high -> back to WAIT_START (busy stays 1, no done). Then send 8'h3C -> uart_data_out=3C.
- Framing error: armed, send 8'hFF with stop bit held 0 -> frame_err=1, no done, uart_data_out keeps the previous value. Re-arm -> frame_err=0 the cycle after init_rx.
- Reset mid-frame: assert rst during data bit 4 of 8'h55 -> IDLE next cycle, busy=0, no done, uart_data_out=00.
- Not armed: send 8'h12 with init_rx=0 -> busy stays 0, no done, uart_data_out unchanged. Then arm and send 8'h34 -> uart_data_out=34.

Source files
------------

// File: rtl/uart_receiver.sv
// 8N1 serial receive engine: synchronises the line, validates the start bit at
// half-bit, samples 8 data bits LSB-first at mid-bit and checks the stop bit.
module uart_receiver #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init_rx,
    input  logic       uart_rx,
    output logic [7:0] uart_data_out,
    output logic       uart_rx_busy,
    output logic       done,
    output logic       frame_err
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_TC = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state, state_n;
    logic [1:0]       rx_sync;
    logic             rx_s;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;

    logic cnt_clr, cnt_inc, idx_clr, sample, load_out, set_ferr, clr_ferr;

    assign rx_s = rx_sync[1];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        idx_clr  = 1'b0;
        sample   = 1'b0;
        load_out = 1'b0;
        set_ferr = 1'b0;
        clr_ferr = 1'b0;
        unique case (state)
            IDLE: begin
                if (init_rx) begin
                    state_n  = WAIT_START;
                    clr_ferr = 1'b1;
                end
            end
            WAIT_START: begin
                if (!rx_s) begin
                    state_n = START;
                    cnt_clr = 1'b1;
                end
            end
            START: begin
                if (baud_cnt == HALF_TC) begin
                    cnt_clr = 1'b1;
                    // A line that has returned high by mid-start-bit is noise.
                    if (!rx_s) begin
                        state_n = DATA;
                        idx_clr = 1'b1;
                    end else begin
                        state_n = WAIT_START;
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DATA: begin
                if (baud_cnt == FULL_TC) begin
                    cnt_clr = 1'b1;
                    sample  = 1'b1;
                    if (bit_idx == 3'd7) state_n = STOP;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            STOP: begin
                if (baud_cnt == FULL_TC) begin
                    cnt_clr = 1'b1;
                    state_n = IDLE;
                    if (rx_s) load_out = 1'b1;
                    else      set_ferr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync       <= 2'b11;
            baud_cnt      <= '0;
            bit_idx       <= '0;
            shift_reg     <= '0;
            uart_data_out <= '0;
            uart_rx_busy  <= 1'b0;
            done          <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            rx_sync <= {rx_sync[0], uart_rx};

            if (cnt_clr)      baud_cnt <= '0;
            else if (cnt_inc) baud_cnt <= baud_cnt + 1'b1;

            if (idx_clr) begin
                bit_idx <= '0;
            end else if (sample) begin
                shift_reg[bit_idx] <= rx_s;
                bit_idx            <= bit_idx + 1'b1;
            end

            if (load_out) uart_data_out <= shift_reg;
            done <= load_out;

            if (set_ferr)      frame_err <= 1'b1;
            else if (clr_ferr) frame_err <= 1'b0;

            // Registered from the next state so busy drops with the done pulse.
            uart_rx_busy <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Randomized and directed frames against a frame-level reference model of the receiver.
module tb_uart_receiver;
    localparam int CPB       = 50000000 / 115200;      // 434
    localparam int DONE_CYC  = 2 + CPB / 2 + 9 * CPB + 1; // sample index of the done pulse
    localparam int BUSY_SPAN = 9 * CPB + CPB / 2;       // cycles surely before done

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       init_rx = 1'b0;
    logic       uart_rx = 1'b1;
    logic [7:0] uart_data_out;
    logic       uart_rx_busy;
    logic       done;
    logic       frame_err;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state
    bit         m_armed = 1'b0;
    logic [7:0] m_out   = 8'h00;
    logic       m_ferr  = 1'b0;

    uart_receiver dut (
        .clk          (clk),
        .rst          (rst),
        .init_rx      (init_rx),
        .uart_rx      (uart_rx),
        .uart_data_out(uart_data_out),
        .uart_rx_busy (uart_rx_busy),
        .done         (done),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        uart_rx = 1'b1;
        repeat (n) tick();
    endtask

    task automatic arm();
        init_rx = 1'b1;
        tick();
        init_rx = 1'b0;
        m_armed = 1'b1;
        m_ferr  = 1'b0;
        chk("arm_busy", 32'(uart_rx_busy), 32'd1);
        chk("arm_ferr", 32'(frame_err), 32'd0);
    endtask

    // Drives start + 8 data + stop; returns early at cycle abort_at (0 = never).
    task automatic send_frame(input logic [7:0] b, input logic stop, input int abort_at,
                              output int n_done, output int done_at,
                              output int busy_hi, output logic busy_at_done);
        logic [9:0] bits;
        int cyc;
        bits = {stop, b, 1'b0};
        n_done = 0; done_at = -1; busy_hi = 0; busy_at_done = 1'b1; cyc = 0;
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < CPB; c++) begin
                uart_rx = bits[i];
                tick();
                cyc++;
                if (done) begin
                    n_done++;
                    done_at = cyc;
                    busy_at_done = uart_rx_busy;
                end
                if (cyc <= BUSY_SPAN && uart_rx_busy) busy_hi++;
                if (abort_at != 0 && cyc == abort_at) return;
            end
        end
        uart_rx = 1'b1;
    endtask

    // Runs one frame and checks every observable against the model's prediction.
    task automatic frame_check(input string tag, input logic [7:0] b, input logic stop);
        int nd, da, bh;
        logic bd;
        bit was_armed;
        was_armed = m_armed;
        send_frame(b, stop, 0, nd, da, bh, bd);
        if (was_armed && stop) begin
            m_out = b;
            m_armed = 1'b0;
        end else if (was_armed) begin
            m_ferr = 1'b1;
            m_armed = 1'b0;
        end
        chk({tag, "_ndone"}, 32'(nd), (was_armed && stop) ? 32'd1 : 32'd0);
        chk({tag, "_data"}, 32'(uart_data_out), 32'(m_out));
        chk({tag, "_ferr"}, 32'(frame_err), 32'(m_ferr));
        chk({tag, "_busy"}, 32'(bh), was_armed ? 32'(BUSY_SPAN) : 32'd0);
        if (was_armed && stop) begin
            chk({tag, "_done_at"}, 32'(da), 32'(DONE_CYC));
            chk({tag, "_busy_at_done"}, 32'(bd), 32'd0);
        end
        idle(20);
        chk({tag, "_idle_busy"}, 32'(uart_rx_busy), 32'd0);
    endtask

    initial begin
        int nd, da, bh;
        logic bd;
        logic [7:0] rb;
        logic rs;
        bit ra;

        // reset
        repeat (3) tick();
        chk("rst_data", 32'(uart_data_out), 32'h00);
        chk("rst_busy", 32'(uart_rx_busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        rst = 1'b0;
        idle(5);

        // nominal
        arm();
        frame_check("a5", 8'hA5, 1'b1);

        // glitch shorter than half a bit, then a real frame
        arm();
        uart_rx = 1'b0;
        repeat (100) tick();
        uart_rx = 1'b1;
        nd = 0; bh = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (done) nd++;
            if (uart_rx_busy) bh++;
        end
        chk("glitch_ndone", 32'(nd), 32'd0);
        chk("glitch_busy", 32'(bh), 32'd400);
        chk("glitch_ferr", 32'(frame_err), 32'd0);
        frame_check("3c", 8'h3C, 1'b1);

        // framing error, then re-arm clears it
        arm();
        frame_check("ff_bad_stop", 8'hFF, 1'b0);
        chk("ferr_sticky", 32'(frame_err), 32'd1);
        arm();
        frame_check("5a", 8'h5A, 1'b1);

        // reset during data bit 4
        arm();
        send_frame(8'h55, 1'b1, 5 * CPB + CPB / 2, nd, da, bh, bd);
        chk("abort_ndone", 32'(nd), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_armed = 1'b0; m_out = 8'h00; m_ferr = 1'b0;
        chk("abort_busy", 32'(uart_rx_busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_data", 32'(uart_data_out), 32'h00);
        idle(CPB * 5);
        chk("abort_after_done", 32'(done), 32'd0);

        // not armed: line activity ignored
        frame_check("unarmed_12", 8'h12, 1'b1);
        arm();
        frame_check("34", 8'h34, 1'b1);

        // randomized frames
        for (int k = 0; k < 6; k++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            ra = ($urandom_range(0, 4) != 0);
            idle($urandom_range(1, 50));
            if (ra) arm();
            frame_check($sformatf("rnd%0d", k), rb, rs);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
